// File: rtl/mpmb_pkg.sv
// Shared types and sizing helpers for the multi-port memory bank.
package mpmb_pkg;

  typedef enum logic {
    RDW_READ_FIRST,
    RDW_WRITE_FIRST
  } rdw_mode_e;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } mpmb_state_e;

  function automatic int nbytes(input int width);
    return width / 8;
  endfunction

  // Width of a port index, kept at least 1 bit so vectors stay legal.
  function automatic int idx_width(input int nports);
    return (nports > 1) ? $clog2(nports) : 1;
  endfunction

endpackage

// File: rtl/mpmb_wr_arbiter.sv
// Same-address write arbitration: lowest-index writer wins; also tells each
// port which writer (if any) targets its address, for read-during-write forwarding.
module mpmb_wr_arbiter
  import mpmb_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int ADDR   = 10,
  localparam int IDXW  = idx_width(NPORTS)
) (
  input  logic [NPORTS-1:0]            en,
  input  logic [NPORTS-1:0]            we,
  input  logic [NPORTS-1:0][ADDR-1:0]  addr,
  output logic [NPORTS-1:0]            grant,
  output logic [NPORTS-1:0]            lose,
  output logic [NPORTS-1:0]            wr_hit,
  output logic [NPORTS-1:0][IDXW-1:0]  win_idx
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant   = '0;
    lose    = '0;
    wr_hit  = '0;
    win_idx = '0;
    for (int p = 0; p < NPORTS; p++) begin
      // Scan downwards so the lowest-index matching writer is the one left standing.
      for (int q = NPORTS - 1; q >= 0; q--) begin
        if (en[q] && we[q] && (addr[q] == addr[p])) begin
          wr_hit[p]  = 1'b1;
          win_idx[p] = IDXW'(q);
        end
      end
      grant[p] = en[p] && we[p] && (win_idx[p] == IDXW'(p));
      lose[p]  = en[p] && we[p] && !grant[p];
    end
  end

endmodule

// File: rtl/multi_port_memory_bank.sv
// N-port shared memory bank with byte enables, write arbitration, selectable
// read-during-write policy, optional output register and a zeroing sweep after reset.
module multi_port_memory_bank
  import mpmb_pkg::*;
#(
  parameter int        WIDTH    = 32,
  parameter int        ADDR     = 10,
  parameter int        NPORTS   = 4,
  parameter rdw_mode_e RDW_MODE = RDW_READ_FIRST,
  parameter bit        OUT_REG  = 1'b0,
  localparam int       NBYTES   = nbytes(WIDTH),
  localparam int       DEPTH    = 2 ** ADDR,
  localparam int       IDXW     = idx_width(NPORTS)
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [NPORTS-1:0]               i_en,
  input  logic [NPORTS-1:0]               i_we,
  input  logic [NPORTS-1:0][NBYTES-1:0]   i_be,
  input  logic [NPORTS-1:0][ADDR-1:0]     i_addr,
  input  logic [NPORTS-1:0][WIDTH-1:0]    i_din,
  output logic [NPORTS-1:0][WIDTH-1:0]    o_dout,
  output logic [NPORTS-1:0]               o_dvalid,
  output logic [NPORTS-1:0]               o_collision,
  output logic                            o_init_done
);

  localparam logic [ADDR:0] SWEEP_LAST = (ADDR + 1)'(DEPTH - 1);

  mpmb_state_e   state;
  logic [ADDR:0] sweep_cnt;
  logic          run;
  logic [NPORTS-1:0] en_run;
  logic [NPORTS-1:0] rd_req;

  logic [NPORTS-1:0]           grant;
  logic [NPORTS-1:0]           lose;
  logic [NPORTS-1:0]           wr_hit;
  logic [NPORTS-1:0][IDXW-1:0] win_idx;

  logic [WIDTH-1:0]               mem [DEPTH];
  logic [NPORTS-1:0][WIDTH-1:0]   rd_word;
  logic [NPORTS-1:0][WIDTH-1:0]   s1_dout;
  logic [NPORTS-1:0]              s1_dv;
  logic [NPORTS-1:0]              s1_col;

  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_rst) begin
      state       <= ST_INIT;
      sweep_cnt   <= '0;
      o_init_done <= 1'b0;
    end else if (state == ST_INIT) begin
      if (sweep_cnt == SWEEP_LAST) begin
        state       <= ST_RUN;
        o_init_done <= 1'b1;
      end else begin
        sweep_cnt <= sweep_cnt + 1'b1;
      end
    end
  end

  assign run    = (state == ST_RUN);
  assign en_run = i_en & {NPORTS{run}};
  assign rd_req = en_run & ~i_we;

  mpmb_wr_arbiter #(
    .NPORTS (NPORTS),
    .ADDR   (ADDR)
  ) u_arb (
    .en      (en_run),
    .we      (i_we),
    .addr    (i_addr),
    .grant   (grant),
    .lose    (lose),
    .wr_hit  (wr_hit),
    .win_idx (win_idx)
  );

  // NOTE: the storage array is deliberately not reset; the post-reset sweep defines its contents.
  always_ff @(posedge i_clk) begin
    if (!run) begin
      mem[sweep_cnt[ADDR-1:0]] <= '0;
    end else begin
      // Granted writers always target distinct addresses, so these never overlap.
      for (int p = 0; p < NPORTS; p++) begin
        if (grant[p]) begin
          for (int b = 0; b < NBYTES; b++) begin
            if (i_be[p][b]) mem[i_addr[p]][8*b +: 8] <= i_din[p][8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int p = 0; p < NPORTS; p++) begin
      rd_word[p] = mem[i_addr[p]];
      if ((RDW_MODE == RDW_WRITE_FIRST) && wr_hit[p]) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (i_be[win_idx[p]][b]) rd_word[p][8*b +: 8] = i_din[win_idx[p]][8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_dout <= '0;
      s1_dv   <= '0;
      s1_col  <= '0;
    end else begin
      s1_dv  <= rd_req;
      s1_col <= lose;
      // Data lanes only load on a read, so the last result is held otherwise.
      for (int p = 0; p < NPORTS; p++) begin
        if (rd_req[p]) s1_dout[p] <= rd_word[p];
      end
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          o_dout      <= '0;
          o_dvalid    <= '0;
          o_collision <= '0;
        end else begin
          o_dvalid    <= s1_dv;
          o_collision <= s1_col;
          for (int p = 0; p < NPORTS; p++) begin
            if (s1_dv[p]) o_dout[p] <= s1_dout[p];
          end
        end
      end
    end else begin : g_no_out_reg
      assign o_dout      = s1_dout;
      assign o_dvalid    = s1_dv;
      assign o_collision = s1_col;
    end
  endgenerate

endmodule

// File: tb/tb_multi_port_memory_bank.sv
// Bench for multi_port_memory_bank: a read-first/unregistered instance and a
// write-first/registered instance share stimulus and are checked against a word-level model.
module tb_multi_port_memory_bank;
  import mpmb_pkg::*;

  localparam int WIDTH  = 32;
  localparam int ADDR   = 10;
  localparam int NPORTS = 4;
  localparam int NBYTES = WIDTH / 8;
  localparam int DEPTH  = 1 << ADDR;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NPORTS-1:0]             en, we;
  logic [NPORTS-1:0][NBYTES-1:0] be;
  logic [NPORTS-1:0][ADDR-1:0]   addr;
  logic [NPORTS-1:0][WIDTH-1:0]  din;

  logic [NPORTS-1:0][WIDTH-1:0]  a_dout, b_dout;
  logic [NPORTS-1:0]             a_dv, a_col, b_dv, b_col;
  logic                          a_done, b_done;

  int checks = 0;
  int errors = 0;

  // Reference model: memory image, edges since reset release, expected outputs.
  logic [WIDTH-1:0] mdl [DEPTH];
  int init_cnt = 0;
  logic [NPORTS-1:0][WIDTH-1:0] ea_dout, eb1_dout, eb2_dout;
  logic [NPORTS-1:0] ea_dv, ea_col, eb1_dv, eb1_col, eb2_dv, eb2_col;

  always #5 clk = ~clk;

  multi_port_memory_bank #(
    .WIDTH(WIDTH), .ADDR(ADDR), .NPORTS(NPORTS),
    .RDW_MODE(RDW_READ_FIRST), .OUT_REG(1'b0)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_we(we), .i_be(be),
    .i_addr(addr), .i_din(din), .o_dout(a_dout), .o_dvalid(a_dv),
    .o_collision(a_col), .o_init_done(a_done)
  );

  multi_port_memory_bank #(
    .WIDTH(WIDTH), .ADDR(ADDR), .NPORTS(NPORTS),
    .RDW_MODE(RDW_WRITE_FIRST), .OUT_REG(1'b1)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_we(we), .i_be(be),
    .i_addr(addr), .i_din(din), .o_dout(b_dout), .o_dvalid(b_dv),
    .o_collision(b_col), .o_init_done(b_done)
  );

  function automatic int winner(input logic [ADDR-1:0] a);
    for (int q = 0; q < NPORTS; q++)
      if (en[q] && we[q] && addr[q] == a) return q;
    return -1;
  endfunction

  task automatic idle();
    en = '0; we = '0; be = '0; addr = '0; din = '0;
  endtask

  task automatic randomize_inputs(input int max_addr);
    for (int p = 0; p < NPORTS; p++) begin
      en[p]   = 1'($urandom_range(0, 1));
      we[p]   = 1'($urandom_range(0, 1));
      be[p]   = NBYTES'($urandom);
      addr[p] = ADDR'($urandom_range(0, max_addr));
      din[p]  = $urandom;
    end
  endtask

  // One clock edge: advance the model from the sampled inputs, then settle 1 time unit.
  task automatic step();
    logic [WIDTH-1:0] old_w, fwd_w;
    int w;
    bit run;
    @(posedge clk);
    run = (init_cnt >= DEPTH);
    eb2_dv  = eb1_dv;
    eb2_col = eb1_col;
    for (int p = 0; p < NPORTS; p++) if (eb1_dv[p]) eb2_dout[p] = eb1_dout[p];
    ea_dv = '0; ea_col = '0; eb1_dv = '0; eb1_col = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (run && en[p]) begin
        w = winner(addr[p]);
        if (we[p]) begin
          ea_col[p]  = (w != p);
          eb1_col[p] = (w != p);
        end else begin
          old_w = mdl[addr[p]];
          fwd_w = old_w;
          if (w >= 0)
            for (int b = 0; b < NBYTES; b++)
              if (be[w][b]) fwd_w[8*b +: 8] = din[w][8*b +: 8];
          ea_dv[p] = 1'b1;  ea_dout[p]  = old_w;
          eb1_dv[p] = 1'b1; eb1_dout[p] = fwd_w;
        end
      end
    end
    if (run) begin
      for (int p = 0; p < NPORTS; p++)
        if (en[p] && we[p] && winner(addr[p]) == p)
          for (int b = 0; b < NBYTES; b++)
            if (be[p][b]) mdl[addr[p]][8*b +: 8] = din[p][8*b +: 8];
    end else begin
      init_cnt++;
      if (init_cnt == DEPTH) for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    end
    #1;
  endtask

  // Assert reset asynchronously, confirm outputs clear at once, then release.
  task automatic apply_reset();
    idle();
    rst = 1'b1;
    #1;
    checks++;
    if ({a_dout, b_dout, a_dv, b_dv, a_col, b_col, a_done, b_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: a_dout=%h b_dout=%h a_dv=%b b_dv=%b a_col=%b b_col=%b done=%b%b, required all 0",
               a_dout, b_dout, a_dv, b_dv, a_col, b_col, a_done, b_done);
    end
    ea_dout = '0; eb1_dout = '0; eb2_dout = '0;
    ea_dv = '0; ea_col = '0; eb1_dv = '0; eb1_col = '0; eb2_dv = '0; eb2_col = '0;
    init_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Random requests during the sweep must be ignored; done must rise after exactly DEPTH edges.
  task automatic wait_init();
    int rise = -1;
    int bad = 0;
    for (int k = 1; k <= DEPTH + 8 && rise < 0; k++) begin
      randomize_inputs(DEPTH - 1);
      step();
      if ({a_dv, a_col, b_dv, b_col} !== '0) bad++;
      if (a_done) rise = k;
    end
    idle();
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL init_ignored: %0d cycles with dvalid/collision during sweep, required 0", bad);
    end
    checks++;
    if (rise != DEPTH) begin
      errors++;
      $display("FAIL init_done_rise: rose after %0d edges, required %0d", rise, DEPTH);
    end
    checks++;
    if (b_done !== a_done) begin
      errors++;
      $display("FAIL init_done_b: b_done=%b, required %b", b_done, a_done);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    wait_init();
    // Request on the first cycle done reads 1 must be served.
    en = '1; we = '0; for (int p = 0; p < NPORTS; p++) addr[p] = ADDR'(5);
    step();
    idle();
    checks++;
    if (a_dv !== '1 || a_dout !== '0) begin
      errors++;
      $display("FAIL reset_read5_a: dv=%b dout=%h, required dv=1111 dout=0", a_dv, a_dout);
    end
    step();
    checks++;
    if (b_dv !== '1 || b_dout !== '0) begin
      errors++;
      $display("FAIL reset_read5_b: dv=%b dout=%h, required dv=1111 dout=0", b_dv, b_dout);
    end
  endtask

  task automatic test_byte_enable();
    idle(); en[0] = 1; we[0] = 1; be[0] = 4'b1111; addr[0] = 3; din[0] = 32'hAABBCCDD;
    step();
    be[0] = 4'b0101; din[0] = 32'h11223344;
    step();
    idle(); en[0] = 1; addr[0] = 3;
    step();
    idle();
    checks++;
    if (a_dv[0] !== 1'b1 || a_dout[0] !== 32'hAA22CC44 || a_dout[0] !== ea_dout[0]) begin
      errors++;
      $display("FAIL byte_enable_a: dv=%b dout=%h, required 1 AA22CC44", a_dv[0], a_dout[0]);
    end
    step();
    checks++;
    if (b_dv[0] !== 1'b1 || b_dout[0] !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL byte_enable_b: dv=%b dout=%h, required 1 AA22CC44", b_dv[0], b_dout[0]);
    end
  endtask

  task automatic test_collision();
    idle();
    en[1] = 1; we[1] = 1; be[1] = '1; addr[1] = 7; din[1] = 32'h1;
    en[2] = 1; we[2] = 1; be[2] = '1; addr[2] = 7; din[2] = 32'h2;
    step();
    idle();
    checks++;
    if (a_col !== 4'b0100 || a_col !== ea_col) begin
      errors++;
      $display("FAIL collision_a: col=%b, required 0100", a_col);
    end
    step();
    checks++;
    if (b_col !== 4'b0100 || a_col !== 4'b0000) begin
      errors++;
      $display("FAIL collision_b: b_col=%b a_col=%b, required 0100 0000", b_col, a_col);
    end
    en[1] = 1; addr[1] = 7;
    step();
    idle();
    checks++;
    if (a_dout[1] !== 32'h1 || a_dv[1] !== 1'b1) begin
      errors++;
      $display("FAIL collision_read: dout=%h dv=%b, required 00000001 1", a_dout[1], a_dv[1]);
    end
    step();
  endtask

  task automatic test_rdw();
    idle(); en[0] = 1; we[0] = 1; be[0] = '1; addr[0] = 9; din[0] = 32'h55;
    step();
    din[0] = 32'h99;
    en[3] = 1; we[3] = 0; addr[3] = 9;
    step();
    idle();
    checks++;
    if (a_dout[3] !== 32'h55 || a_dv[3] !== 1'b1) begin
      errors++;
      $display("FAIL rdw_read_first: dout=%h dv=%b, required 00000055 1", a_dout[3], a_dv[3]);
    end
    step();
    checks++;
    if (b_dout[3] !== 32'h99 || b_dv[3] !== 1'b1) begin
      errors++;
      $display("FAIL rdw_write_first: dout=%h dv=%b, required 00000099 1", b_dout[3], b_dv[3]);
    end
  endtask

  task automatic test_back_to_back();
    logic [NPORTS-1:0][WIDTH-1:0] snap;
    idle();
    for (int i = 0; i < 8; i++) begin
      en = '1; we = '0;
      for (int p = 0; p < NPORTS; p++) addr[p] = ADDR'((i + p) % 8);
      step();
      checks++;
      if (a_dv !== '1) begin
        errors++;
        $display("FAIL b2b_a_dv[%0d]: %b, required 1111", i, a_dv);
      end
      checks++;
      if (i == 0) begin
        if (b_dv !== '0) begin
          errors++;
          $display("FAIL b2b_latency: b_dv=%b one cycle after first read, required 0000", b_dv);
        end
      end else begin
        for (int p = 0; p < NPORTS; p++) begin
          if (b_dv[p] !== 1'b1 || b_dout[p] !== mdl[(i - 1 + p) % 8]) begin
            errors++;
            $display("FAIL b2b_b[%0d] port %0d: dv=%b dout=%h, required 1 %h",
                     i, p, b_dv[p], b_dout[p], mdl[(i - 1 + p) % 8]);
          end
        end
      end
    end
    idle();
    step();
    checks++;
    if (b_dv !== '1 || b_dout !== eb2_dout) begin
      errors++;
      $display("FAIL b2b_tail: dv=%b dout=%h, required 1111 %h", b_dv, b_dout, eb2_dout);
    end
    snap = b_dout;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (b_dv !== '0 || b_dout !== snap) begin
        errors++;
        $display("FAIL b2b_hold[%0d]: dv=%b dout=%h, required 0000 %h", k, b_dv, b_dout, snap);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      randomize_inputs(15);
      step();
      checks++;
      if (a_dv !== ea_dv || a_col !== ea_col || a_dout !== ea_dout) begin
        errors++;
        $display("FAIL random_a[%0d]: dv=%b col=%b dout=%h, required %b %b %h",
                 c, a_dv, a_col, a_dout, ea_dv, ea_col, ea_dout);
      end
      checks++;
      if (b_dv !== eb2_dv || b_col !== eb2_col || b_dout !== eb2_dout) begin
        errors++;
        $display("FAIL random_b[%0d]: dv=%b col=%b dout=%h, required %b %b %h",
                 c, b_dv, b_col, b_dout, eb2_dv, eb2_col, eb2_dout);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    // Reset while read data is live, then again partway through the sweep.
    en = '1; we = '0; addr = '0;
    step();
    apply_reset();
    for (int k = 0; k < 300; k++) step();
    checks++;
    if (a_done !== 1'b0 || b_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_sweep_done: done=%b%b at sweep 300, required 00", a_done, b_done);
    end
    apply_reset();
    wait_init();
    en[0] = 1; addr[0] = 3;
    step();
    idle();
    checks++;
    if (a_dout[0] !== 32'h0 || a_dv[0] !== 1'b1) begin
      errors++;
      $display("FAIL resweep_zero: dout=%h dv=%b, required 00000000 1", a_dout[0], a_dv[0]);
    end
    step();
  endtask

  initial begin
    idle();
    test_reset();
    test_byte_enable();
    test_collision();
    test_rdw();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
